// File: rtl/relu_vec_pkg.sv
// relu_vec_pkg -- shared definitions for the vector ReLU block.
//   * IEEE-754 single-precision field positions and useful constants
//   * activation mode encodings carried on the 2-bit mode port
//   * per-lane classification record and the function that builds it
package relu_vec_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [7:0]  EXP_BIAS    = 8'd127;
  localparam logic [7:0]  EXP_ALL1    = 8'hFF;

  localparam logic [1:0] MODE_RELU   = 2'b00;
  localparam logic [1:0] MODE_DRELU  = 2'b01;
  localparam logic [1:0] MODE_LEAKY  = 2'b10;
  localparam logic [1:0] MODE_DLEAKY = 2'b11;

  // Classification is done at the input and registered with the data so
  // the second stage only has to select, not compare.
  typedef struct packed {
    logic is_nan;     // exponent all ones, mantissa nonzero
    logic is_zero;    // +0 or -0
    logic is_inf;     // exponent all ones, mantissa zero
    logic exp_small;  // biased exponent <= leak shift (flushes on leak)
  } lane_class_t;

  function automatic lane_class_t classify(input logic [31:0] x,
                                           input logic [7:0]  leak_shift);
    lane_class_t c;
    logic [7:0]  e;
    logic        m_nz;
    e         = x[EXP_MSB:EXP_LSB];
    m_nz      = |x[MAN_MSB:0];
    c.is_nan    = (e == EXP_ALL1) && m_nz;
    c.is_inf    = (e == EXP_ALL1) && !m_nz;
    c.is_zero   = (e == 8'd0) && !m_nz;
    c.exp_small = (e <= leak_shift);
    return c;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// relu_lane -- combinational activation for one float32 lane.
//   x    : registered lane value
//   mode : registered activation mode for the vector this lane belongs to
//   cls  : registered classification of x
//   z    : activation result (NaN inputs pass through untouched)
module relu_lane
  import relu_vec_pkg::*;
#(
  parameter int LEAK_SHIFT = 6
) (
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  input  lane_class_t cls,
  output logic [31:0] z
);

  logic        sign;
  logic        positive;
  logic [7:0]  leak_exp;
  logic [31:0] leak_slope;

  assign sign       = x[SIGN_BIT];
  // +inf counts as positive; NaN is handled before this matters.
  assign positive   = !sign && !cls.is_zero;
  // Multiplying by 2^-LEAK_SHIFT is just an exponent decrement; exp_small
  // guards the underflow case so this subtraction never wraps when used.
  assign leak_exp   = x[EXP_MSB:EXP_LSB] - 8'(LEAK_SHIFT);
  assign leak_slope = {1'b0, EXP_BIAS - 8'(LEAK_SHIFT), 23'd0};

  always_comb begin
    z = x;
    if (!cls.is_nan) begin
      case (mode)
        MODE_RELU:  z = sign ? FP_POS_ZERO : x;
        MODE_DRELU: z = positive ? FP_ONE : FP_POS_ZERO;
        MODE_LEAKY: begin
          if (!sign || cls.is_inf) z = x;
          else if (cls.exp_small)  z = FP_NEG_ZERO;
          else                     z = {1'b1, leak_exp, x[MAN_MSB:0]};
        end
        default:    z = positive ? FP_ONE : leak_slope;
      endcase
    end
  end

endmodule

// File: rtl/relu_vec.sv
// relu_vec -- LANES-wide float32 ReLU / leaky ReLU and derivatives,
// two-stage elastic pipeline (valid/ready on both sides).
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake for x_data + mode
//   x_data              : lane i at [32i+31:32i]
//   mode                : 00 relu, 01 d/dx relu, 10 leaky, 11 d/dx leaky
//   out_valid/out_ready : output handshake for z_data
//   z_data              : results, same packing as x_data
//   nan_seen, clr_flag  : sticky "NaN accepted" flag and its clear
module relu_vec
  import relu_vec_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   x_data,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   z_data,
  output logic                  nan_seen,
  input  logic                  clr_flag
);

  logic                s1_valid_reg;
  logic                s2_valid_reg;
  logic [1:0]          s1_mode_reg;
  logic [32*LANES-1:0] s1_x_reg;
  logic [32*LANES-1:0] z_reg;
  logic [32*LANES-1:0] z_next;
  logic                nan_seen_reg;
  lane_class_t         cls_in [LANES];
  lane_class_t         s1_cls_reg [LANES];
  logic [LANES-1:0]    lane_nan;
  logic                s2_en;
  logic                accept;

  // Stage 2 can load when empty or being drained; stage 1 can load when
  // empty or moving into stage 2. Nothing here depends on in_valid.
  assign s2_en    = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_en;
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign cls_in[gi]   = classify(x_data[32*gi +: 32], 8'(LEAK_SHIFT));
      assign lane_nan[gi] = cls_in[gi].is_nan;

      relu_lane #(
        .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
        .x    (s1_x_reg[32*gi +: 32]),
        .mode (s1_mode_reg),
        .cls  (s1_cls_reg[gi]),
        .z    (z_next[32*gi +: 32])
      );
    end
  endgenerate

  // Stage 1: vector, its mode and the per-lane classes travel together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= MODE_RELU;
      s1_x_reg     <= '0;
      for (int i = 0; i < LANES; i++) s1_cls_reg[i] <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_mode_reg <= mode;
        s1_x_reg    <= x_data;
        for (int i = 0; i < LANES; i++) s1_cls_reg[i] <= cls_in[i];
      end
    end
  end

  // Stage 2: result register, frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      z_reg        <= '0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) z_reg <= z_next;
    end
  end

  // A NaN arriving in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       nan_seen_reg <= 1'b0;
    else if (accept && |lane_nan)  nan_seen_reg <= 1'b1;
    else if (clr_flag)             nan_seen_reg <= 1'b0;
  end

  assign out_valid = s2_valid_reg;
  assign z_data    = z_reg;
  assign nan_seen  = nan_seen_reg;

endmodule

// File: tb/tb_relu_vec.sv
module tb_relu_vec;

  localparam int LANES = 4;
  localparam int LS    = 6;
  localparam int W     = 32 * LANES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x_data = '0;
  logic [1:0]   mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] z_data;
  logic         nan_seen;
  logic         clr_flag = 1'b0;

  relu_vec #(.LANES(LANES), .LEAK_SHIFT(LS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_data    (x_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_data    (z_data),
    .nan_seen  (nan_seen),
    .clr_flag  (clr_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int acc_count = 0;
  logic [W-1:0] q [$];
  logic         nan_model = 1'b0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] held_z = '0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the activation rules written directly on sign/exponent/mantissa.
  function automatic logic [31:0] ref_lane(input logic [31:0] x, input logic [1:0] m);
    int          e;
    int          ne;
    logic [7:0]  ne8;
    logic        s;
    logic        pos;
    logic [31:0] slope;
    s     = x[31];
    e     = int'(x[30:23]);
    slope = 32'(127 - LS) << 23;
    pos   = !s && (x[30:0] != 31'd0);
    if (e == 255 && x[22:0] != 23'd0) return x;
    case (m)
      2'b00: return s ? 32'h0 : x;
      2'b01: return pos ? 32'h3F800000 : 32'h0;
      2'b10: begin
        if (!s || e == 255) return x;
        ne = e - LS;
        if (ne <= 0) return 32'h80000000;
        ne8 = ne[7:0];
        return {1'b1, ne8, x[22:0]};
      end
      default: return pos ? 32'h3F800000 : slope;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[32*i +: 32] = ref_lane(x[32*i +: 32], m);
    return r;
  endfunction

  function automatic logic has_nan(input logic [W-1:0] x);
    for (int i = 0; i < LANES; i++)
      if (x[32*i+23 +: 8] == 8'hFF && x[32*i +: 23] != 23'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 11))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FC0_0000;
      5: return 32'hFFC0_0001;
      6: return {1'b1, 8'($urandom_range(0, 8)), 23'($urandom)};
      7: return {1'b0, 8'($urandom_range(0, 2)), 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive, check handshakes against the scoreboard,
  // then check the sticky flag after the edge. Called and returns at negedge.
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [1:0] m,
                       input logic ordy, input logic clr);
    logic acc;
    logic take;
    in_valid  = iv;
    x_data    = x;
    mode      = m;
    out_ready = ordy;
    clr_flag  = clr;
    #1;
    if (hold_pending) begin
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_data", z_data, held_z);
    end
    acc  = iv && in_ready;
    take = out_valid && out_ready;
    if (take) begin
      if (q.size() == 0) chk("spurious_out", W'(out_valid), W'(0));
      else chk("z_order", z_data, q.pop_front());
    end
    hold_pending = out_valid && !out_ready;
    held_z       = z_data;
    if (acc) begin
      acc_count++;
      q.push_back(ref_vec(x, m));
      $display("accept x=%h mode=%b", x, m);
    end
    if (acc && has_nan(x)) nan_model = 1'b1;
    else if (clr)          nan_model = 1'b0;
    @(posedge clk);
    #1;
    chk("nan_seen", W'(nan_seen), W'(nan_model));
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
    chk("flush_empty", W'(q.size()), W'(0));
  endtask

  logic [W-1:0] v;
  int           acc_before;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_z_data", z_data, '0);
    chk("rst_nan_seen", W'(nan_seen), W'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));

    // Basic relu, latency 2
    v = pack4(32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7F800000);
    cycle(1'b1, v, 2'b00, 1'b1, 1'b0);
    chk("lat_cycle1", W'(out_valid), W'(0));
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
    chk("lat_cycle2", W'(out_valid), W'(1));
    chk("relu_vec", z_data, pack4(32'h3F800000, 32'h0, 32'h0, 32'h7F800000));
    flush();

    // Leaky relu
    v = pack4(32'hBF800000, 32'h80800000, 32'h40000000, 32'hFF800000);
    cycle(1'b1, v, 2'b10, 1'b1, 1'b0);
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
    chk("leaky_vec", z_data, pack4(32'hBC800000, 32'h80000000, 32'h40000000, 32'hFF800000));
    flush();

    // Derivative modes back to back
    v = pack4(32'hC0000000, 32'h40400000, 32'h00000000, 32'h3F800000);
    cycle(1'b1, v, 2'b01, 1'b1, 1'b0);
    cycle(1'b1, v, 2'b11, 1'b1, 1'b0);
    chk("drelu_vec", z_data, pack4(32'h0, 32'h3F800000, 32'h0, 32'h3F800000));
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
    chk("dleaky_vec", z_data, pack4(32'h3C800000, 32'h3F800000, 32'h3C800000, 32'h3F800000));
    flush();

    // Backpressure: 5 stalled cycles with input offered every cycle
    acc_before = acc_count;
    for (int i = 0; i < 5; i++)
      cycle(1'b1, pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane()),
            2'($urandom_range(0, 3)), 1'b0, 1'b0);
    chk("stall_accepts", W'(acc_count - acc_before), W'(2));
    chk("stall_in_ready", W'(in_ready), W'(0));
    flush();

    // NaN pass-through and sticky flag
    v = pack4(32'h3F800000, 32'h40000000, 32'h7FC00000, 32'hBF800000);
    cycle(1'b1, v, 2'b00, 1'b1, 1'b0);
    chk("nan_set", W'(nan_seen), W'(1));
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
    chk("nan_vec", z_data, pack4(32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h0));
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b1);
    chk("nan_cleared", W'(nan_seen), W'(0));
    cycle(1'b1, v, 2'b10, 1'b1, 1'b1);
    chk("nan_set_wins", W'(nan_seen), W'(1));
    flush();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0),
            pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane()),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
    flush();

    // Reset with two vectors in flight
    cycle(1'b1, pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane()), 2'b00, 1'b0, 1'b0);
    cycle(1'b1, pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane()), 2'b10, 1'b0, 1'b0);
    chk("inflight_valid", W'(out_valid), W'(1));
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_z_data", z_data, '0);
    chk("arst_nan_seen", W'(nan_seen), W'(0));
    q.delete();
    hold_pending = 1'b0;
    nan_model    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0);
      chk("post_rst_no_out", W'(out_valid), W'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
